// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS link: arbiter state encoding, grant codes
// and the default serializer word width.
package lvds_link_pkg;

  localparam int unsigned DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RDY = 2'd2,
    GAP      = 2'd3
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_HOST = 2'b01;
  localparam logic [1:0] GNT_ECHO = 2'b10;

endpackage

// File: rtl/lvds_rdy_sync.sv
// Two-flop synchronizer for the remote RDY line; resets to "not ready".
module lvds_rdy_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/lvds_tx_scheduler.sv
// Round-robin burst arbiter sharing one LVDS transmit lane between the host
// and echo word sources, throttled by the synchronized remote RDY line.
module lvds_tx_scheduler
  import lvds_link_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  input  logic              RDY_from_recv,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int unsigned WC_W = $clog2(BURST_MAX + 1);
  localparam int unsigned TC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(BURST_MAX - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              rr_q, rr_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [TC_W-1:0]   tc_q, tc_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_q, err_d;

  logic              rdy_s;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              send_ready;
  logic              xfer;

  lvds_rdy_sync u_rdy_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (RDY_from_recv),
    .q     (rdy_s)
  );

  assign sel_valid  = gnt_q[1] ? req1_valid : req0_valid;
  assign sel_last   = gnt_q[1] ? req1_last  : req0_last;
  assign sel_data   = gnt_q[1] ? req1_data  : req0_data;
  assign send_ready = (state_q == SEND) && rdy_s;
  assign xfer       = send_ready && sel_valid;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    wc_d       = wc_q;
    tc_d       = tc_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    err_d      = err_clr ? 1'b0 : err_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = (req0_valid && (!req1_valid || !rr_q)) ? GNT_HOST : GNT_ECHO;
          wc_d    = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          tx_valid_d = 1'b1;
          tx_data_d  = sel_data;
          wc_d       = wc_q + 1'b1;
        end
        if (!rdy_s) begin
          tc_d    = '0;
          state_d = WAIT_RDY;
        end else if (xfer && (sel_last || wc_q == WC_LAST)) begin
          // Pointer moves to whoever did not own this burst.
          rr_d    = gnt_q[0];
          gnt_d   = GNT_NONE;
          state_d = GAP;
        end
      end
      WAIT_RDY: begin
        if (rdy_s) begin
          state_d = SEND;
        end else if (tc_q == TC_LAST) begin
          // A fresh timeout wins over a simultaneous clear request.
          err_d   = 1'b1;
          rr_d    = gnt_q[0];
          gnt_d   = GNT_NONE;
          state_d = GAP;
        end else begin
          tc_d = tc_q + 1'b1;
        end
      end
      GAP: begin
        gnt_d   = GNT_NONE;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = GNT_NONE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_NONE;
      rr_q       <= 1'b0;
      wc_q       <= '0;
      tc_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      wc_q       <= wc_d;
      tc_q       <= tc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  assign req0_ready  = send_ready && gnt_q[0];
  assign req1_ready  = send_ready && gnt_q[1];
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign grant       = gnt_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_lvds_tx_scheduler.sv
// Directed bench for lvds_tx_scheduler: per-cycle valid/grant patterns and
// transmitted word order are compared with hand-derived expectations.
module tb_lvds_tx_scheduler;

  logic       CLK;
  logic       RST_N;
  logic       req0_valid, req0_last, req0_ready;
  logic [3:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [3:0] req1_data;
  logic       RDY_from_recv;
  logic [3:0] tx_data;
  logic       tx_valid;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  logic [4:0]  q0[$];
  logic [4:0]  q1[$];
  logic [3:0]  txq[$];
  logic [3:0]  expq[$];
  logic [31:0] vpat;
  logic [31:0] gpat;
  int          lowcnt;
  int          gcnt;

  lvds_tx_scheduler #(
    .DATA_W    (4),
    .BURST_MAX (8),
    .TIMEOUT   (255)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_last     (req0_last),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_last     (req1_last),
    .req1_ready    (req1_ready),
    .RDY_from_recv (RDY_from_recv),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .grant         (grant),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .err_clr       (err_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_txq(input string tag);
    chk({tag, "_count"}, txq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < txq.size()) chk($sformatf("%s_w%0d", tag, i), txq[i], expq[i]);
    end
  endtask

  task automatic apply_src();
    req0_valid = (q0.size() != 0);
    req0_data  = (q0.size() != 0) ? q0[0][3:0] : 4'h0;
    req0_last  = (q0.size() != 0) ? q0[0][4]   : 1'b0;
    req1_valid = (q1.size() != 0);
    req1_data  = (q1.size() != 0) ? q1[0][3:0] : 4'h0;
    req1_last  = (q1.size() != 0) ? q1[0][4]   : 1'b0;
  endtask

  // One clock: handshakes are judged on the values held before the edge.
  task automatic cyc();
    logic h0, h1;
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    @(posedge CLK);
    #1;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    apply_src();
    if (tx_valid) txq.push_back(tx_data);
    vpat = {vpat[30:0], tx_valid};
    gpat = {gpat[29:0], grant};
  endtask

  initial begin
    RST_N = 1'b0;
    RDY_from_recv = 1'b0;
    err_clr = 1'b0;
    apply_src();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 4'h0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    RST_N = 1'b1;
    RDY_from_recv = 1'b1;
    cyc();
    cyc();
    chk("idle_busy", busy, 1'b0);

    // Host sends 1,2,3 (last on 3).
    q0 = '{5'h01, 5'h02, 5'h13};
    apply_src();
    vpat = '0; gpat = '0; txq.delete();
    cyc();
    chk("t1_grant", grant, 2'b01);
    chk("t1_ready0", req0_ready, 1'b1);
    chk("t1_ready1", req1_ready, 1'b0);
    repeat (5) cyc();
    chk("t1_vpat", vpat[5:0], 6'b011100);
    chk("t1_gpat", gpat[11:0], 12'b01_01_01_00_00_00);
    chk("t1_hold", tx_data, 4'h3);
    chk("t1_busy", busy, 1'b0);
    expq = '{4'h1, 4'h2, 4'h3};
    chk_txq("t1_tx");

    // Both sources, 2-word bursts; pointer now favours the echo source.
    q1 = '{5'h04, 5'h15, 5'h06, 5'h17};
    q0 = '{5'h08, 5'h19, 5'h0A, 5'h1B};
    apply_src();
    vpat = '0; gpat = '0; txq.delete();
    repeat (16) cyc();
    chk("t2_vpat", vpat[15:0], 16'h6666);
    chk("t2_gpat", gpat, 32'hA050A050);
    expq = '{4'h4, 4'h5, 4'h8, 4'h9, 4'h6, 4'h7, 4'hA, 4'hB};
    chk_txq("t2_tx");

    // Echo streams 24 words with no last: forced 8-word bursts.
    for (int i = 0; i < 24; i++) q1.push_back({1'b0, 4'(i)});
    apply_src();
    vpat = '0; txq.delete(); gcnt = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (grant == 2'b10) gcnt++;
    end
    chk("t3_vpat", vpat[29:0], {10'h1FE, 10'h1FE, 10'h1FE});
    chk("t3_grant_cycles", gcnt, 24);
    expq.delete();
    for (int i = 0; i < 24; i++) expq.push_back(4'(i));
    chk_txq("t3_tx");

    // RDY low for 10 cycles mid-burst.
    q0 = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h16};
    apply_src();
    vpat = '0; txq.delete(); lowcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (grant == 2'b01 && !req0_ready) lowcnt++;
      if (k == 3) RDY_from_recv = 1'b0;
      if (k == 13) RDY_from_recv = 1'b1;
    end
    chk("t4_vpat", vpat[19:0], 20'h7800C);
    chk("t4_ready_low", lowcnt, 11);
    chk("t4_err", timeout_err, 1'b0);
    expq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    chk_txq("t4_tx");

    // RDY held low until timeout; echo waits for the lane.
    q0 = '{5'h0C, 5'h0D, 5'h1E};
    apply_src();
    txq.delete();
    cyc();
    chk("t5_grant0", grant, 2'b01);
    RDY_from_recv = 1'b0;
    q1.push_back(5'h13);
    apply_src();
    for (int k = 2; k <= 258; k++) begin
      cyc();
      if (k == 100) chk("t5_wait_ready0", req0_ready, 1'b0);
    end
    chk("t5_err_pre", timeout_err, 1'b0);
    chk("t5_grant_pre", grant, 2'b01);
    chk("t5_busy_pre", busy, 1'b1);
    err_clr = 1'b1;
    cyc();
    chk("t5_err_set_beats_clr", timeout_err, 1'b1);
    chk("t5_grant_gap", grant, 2'b00);
    err_clr = 1'b0;
    RDY_from_recv = 1'b1;
    cyc();
    chk("t5_err_sticky", timeout_err, 1'b1);
    err_clr = 1'b1;
    cyc();
    chk("t5_err_cleared", timeout_err, 1'b0);
    chk("t5_grant_echo", grant, 2'b10);
    chk("t5_ready1", req1_ready, 1'b1);
    chk("t5_ready0", req0_ready, 1'b0);
    err_clr = 1'b0;
    repeat (5) cyc();
    chk("t5_busy_end", busy, 1'b0);
    expq = '{4'hC, 4'hD, 4'h3, 4'hE};
    chk_txq("t5_tx");

    // Reset in the middle of a host burst.
    q0 = '{5'h01, 5'h02, 5'h03, 5'h14};
    apply_src();
    repeat (3) cyc();
    chk("t6_tx_before", tx_data, 4'h2);
    #3;
    RST_N = 1'b0;
    #1;
    chk("t6_rst_tx_valid", tx_valid, 1'b0);
    chk("t6_rst_tx_data", tx_data, 4'h0);
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_ready0", req0_ready, 1'b0);
    q1.push_back(5'h19);
    apply_src();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("t6_grant_after_rst", grant, 2'b01);
    chk("t6_busy_after_rst", busy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
